// File: rtl/memory_lane_sequencer_pkg.sv
// Shared definitions for the memory lane sequencer: widths, control codes,
// sentinel address, FSM state encoding, request payload and lane-count helper.
package memory_lane_sequencer_pkg;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned LANE_W = 8;
    localparam int unsigned LANES  = 4;
    localparam int unsigned DATA_W = LANES * LANE_W;
    localparam int unsigned CTL_W  = 3;
    localparam int unsigned CNT_W  = 2;

    localparam logic [ADDR_W-1:0] SENTINEL = 10'h3FF;

    localparam logic [CTL_W-1:0] CTL_NONE = 3'd0;
    localparam logic [CTL_W-1:0] CTL_PUSH = 3'd1;
    localparam logic [CTL_W-1:0] CTL_POP  = 3'd2;
    localparam logic [CTL_W-1:0] CTL_BYTE = 3'd3;
    localparam logic [CTL_W-1:0] CTL_HALF = 3'd4;
    localparam logic [CTL_W-1:0] CTL_WORD = 3'd5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Request captured at accept; write is the effective direction.
    typedef struct packed {
        logic [CTL_W-1:0]        ctl;
        logic                    write;
        logic [LANES*ADDR_W-1:0] addr;
        logic [DATA_W-1:0]       wdata;
    } req_t;

    // Number of byte lanes touched by an access code (0 means no access).
    function automatic logic [2:0] lane_count(input logic [CTL_W-1:0] ctl);
        case (ctl)
            CTL_PUSH, CTL_POP, CTL_BYTE: lane_count = 3'd1;
            CTL_HALF:                    lane_count = 3'd2;
            CTL_WORD:                    lane_count = 3'd4;
            default:                     lane_count = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/lane_data_packer.sv
// Combinational lane data helper.
//   wdata/wr_idx      -> lane_byte_c : store byte for lane wr_idx
//   rdata_cur/rd_idx/byte_in -> rdata_ins_c : rdata_cur with byte_in placed in lane rd_idx
module lane_data_packer
    import memory_lane_sequencer_pkg::*;
(
    input  logic [DATA_W-1:0] wdata,
    input  logic [CNT_W-1:0]  wr_idx,
    output logic [LANE_W-1:0] lane_byte_c,
    input  logic [DATA_W-1:0] rdata_cur,
    input  logic [CNT_W-1:0]  rd_idx,
    input  logic [LANE_W-1:0] byte_in,
    output logic [DATA_W-1:0] rdata_ins_c
);

    // Lane i occupies bits [8i+7:8i]
    always_comb begin
        lane_byte_c = wdata[{wr_idx, 3'b000} +: LANE_W];
    end

    always_comb begin
        rdata_ins_c = rdata_cur;
        rdata_ins_c[{rd_idx, 3'b000} +: LANE_W] = byte_in;
    end

endmodule

// File: rtl/memory_lane_sequencer.sv
// Memory-side responder: serialises a four-lane address bundle into byte
// accesses on a single-port byte-wide RAM, splitting store data and
// assembling load data. Sentinel lane addresses abort with a fault.
// Ports:
//   clock, reset              : clock, async active-high reset
//   req_valid/req_ready       : request handshake (ready only in IDLE)
//   control, req_write        : access code and direction for codes 3-5
//   Address, wdata            : four 10-bit lane addresses, store data
//   ram_addr/ram_we/ram_wdata : RAM request (registered)
//   ram_rdata                 : RAM byte, valid one cycle after ram_addr
//   rdata, done, fault        : load result, completion and abort pulses
module memory_lane_sequencer
    import memory_lane_sequencer_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [CTL_W-1:0]        control,
    input  logic                    req_write,
    input  logic [LANES*ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0]       wdata,
    output logic [ADDR_W-1:0]       ram_addr,
    output logic                    ram_we,
    output logic [LANE_W-1:0]       ram_wdata,
    input  logic [LANE_W-1:0]       ram_rdata,
    output logic [DATA_W-1:0]       rdata,
    output logic                    done,
    output logic                    fault
);

    state_t             state_q, state_d;
    req_t               req_q, req_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  ram_addr_d;
    logic               ram_we_d;
    logic [LANE_W-1:0]  ram_wdata_d;
    logic [DATA_W-1:0]  rdata_d;
    logic               done_d;
    logic               fault_d;
    logic               ready_d;

    logic [2:0]         n_lanes;
    logic               last_lane;
    logic               sentinel_hit;
    logic               eff_write;
    logic [ADDR_W-1:0]  lane [LANES];
    logic [CNT_W-1:0]   wr_idx;
    logic [CNT_W-1:0]   rd_idx;
    logic [LANE_W-1:0]  lane_byte_c;
    logic [DATA_W-1:0]  rdata_ins_c;

    assign n_lanes   = lane_count(req_q.ctl);
    assign last_lane = (cnt_q == CNT_W'(n_lanes - 3'd1));

    // Push always stores, pop always loads; other codes follow req_write
    always_comb begin
        eff_write = req_write;
        if (control == CTL_PUSH) eff_write = 1'b1;
        if (control == CTL_POP)  eff_write = 1'b0;
    end

    // Unpack lane addresses and look for the sentinel in active lanes only
    always_comb begin
        sentinel_hit = 1'b0;
        for (int unsigned i = 0; i < LANES; i++) begin
            lane[i] = req_q.addr[i*ADDR_W +: ADDR_W];
            if ((3'(i) < n_lanes) && (lane[i] == SENTINEL)) sentinel_hit = 1'b1;
        end
    end

    // Registered RAM outputs lead by a cycle: issue lane cnt+1 while in lane cnt.
    // Read data lags by a cycle: capture lane cnt-1, or the last lane in DRAIN.
    assign wr_idx = (state_q == RUN) ? (cnt_q + 2'd1) : 2'd0;
    assign rd_idx = (state_q == DRAIN) ? cnt_q : (cnt_q - 2'd1);

    lane_data_packer u_packer (
        .wdata       (req_q.wdata),
        .wr_idx      (wr_idx),
        .lane_byte_c (lane_byte_c),
        .rdata_cur   (rdata),
        .rd_idx      (rd_idx),
        .byte_in     (ram_rdata),
        .rdata_ins_c (rdata_ins_c)
    );

    // State and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            req_q     <= '0;
            cnt_q     <= '0;
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            ram_wdata <= '0;
            rdata     <= '0;
            done      <= 1'b0;
            fault     <= 1'b0;
            req_ready <= 1'b1;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            cnt_q     <= cnt_d;
            ram_addr  <= ram_addr_d;
            ram_we    <= ram_we_d;
            ram_wdata <= ram_wdata_d;
            rdata     <= rdata_d;
            done      <= done_d;
            fault     <= fault_d;
            req_ready <= ready_d;
        end
    end

    // Next state and next output values
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        cnt_d       = cnt_q;
        ram_addr_d  = ram_addr;
        ram_we_d    = 1'b0;
        ram_wdata_d = ram_wdata;
        rdata_d     = rdata;
        done_d      = 1'b0;
        fault_d     = 1'b0;
        ready_d     = req_ready;

        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (req_valid && req_ready) begin
                    req_d.ctl   = control;
                    req_d.write = eff_write;
                    req_d.addr  = Address;
                    req_d.wdata = wdata;
                    rdata_d     = '0;
                    ready_d     = 1'b0;
                    state_d     = CHECK;
                end
            end
            CHECK: begin
                if ((n_lanes == 3'd0) || sentinel_hit) begin
                    done_d  = 1'b1;
                    fault_d = sentinel_hit;
                    state_d = DONE;
                end else begin
                    cnt_d      = '0;
                    ram_addr_d = lane[0];
                    ram_we_d   = req_q.write;
                    if (req_q.write) ram_wdata_d = lane_byte_c;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (!req_q.write && (cnt_q != '0)) rdata_d = rdata_ins_c;
                if (last_lane) begin
                    if (req_q.write) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = DRAIN;
                    end
                end else begin
                    cnt_d      = wr_idx;
                    ram_addr_d = lane[wr_idx];
                    ram_we_d   = req_q.write;
                    if (req_q.write) ram_wdata_d = lane_byte_c;
                end
            end
            DRAIN: begin
                rdata_d = rdata_ins_c;
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                ready_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                ready_d = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: doc/memory_lane_sequencer.md
Name: memory_lane_sequencer

Overview:
- Memory-side responder for the 40-bit four-lane address bundle and 3-bit access control produced by the address handler.
- Serialises each request into one-byte accesses on a single-port byte-wide RAM.
- On writes, splits the 32-bit write data across lanes; on reads, assembles the returned bytes into a 32-bit word.
- Sits between the address handler / control unit and the data RAM; flags the 0x3FF empty-stack sentinel as a fault instead of touching memory.

Parameters:
- ADDR_W, 10, width of one lane address and of the RAM address.
- LANE_W, 8, RAM data width and lane data width.
- SENTINEL, 10'h3FF, lane address meaning invalid access (pop of empty stack).

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request (high only in IDLE).
- control  in  3  access code: 0 none, 1 push, 2 pop, 3 byte, 4 halfword, 5 word, 6/7 none.
- req_write  in  1  direction for codes 3-5 (1 = store); ignored for 1 (always write) and 2 (always read).
- Address  in  40  {Byte3, Byte2, Byte1, Byte0}, 10 bits per lane.
- wdata  in  32  store data; lane i carries bits [8i+7:8i].
- ram_addr  out  ADDR_W  RAM address.
- ram_we  out  1  RAM write strobe.
- ram_wdata  out  LANE_W  RAM write byte.
- ram_rdata  in  LANE_W  RAM read byte; valid one cycle after ram_addr is presented.
- rdata  out  32  assembled load data; unused lanes zero.
- done  out  1  one-cycle completion pulse.
- fault  out  1  one-cycle pulse, coincident with done, on sentinel abort.

Behaviour:
- Reset (asynchronous, immediate): state IDLE; req_ready=1, ram_we=0, ram_addr=0, ram_wdata=0, rdata=0, done=0, fault=0, lane counter 0.
- Accept: a request is taken when req_valid & req_ready at a rising edge. At that edge, control, effective direction, Address and wdata are registered; later input changes are ignored.
- Lane count N: 1 for codes 1, 2 and 3; 2 for code 4; 4 for code 5; 0 for codes 0, 6 and 7.
- Issue order: lane 0 first, then 1, 2, 3, i.e. descending memory address.
- States:
  - IDLE: on accept, go to CHECK.
  - CHECK (1 cycle): if N=0, go to DONE with rdata=0. If any active lane address equals SENTINEL, go to DONE with fault set and rdata=0, no RAM access. Otherwise go to RUN, counter=0.
  - RUN (N cycles): present ram_addr=lane[counter]. On write, ram_we=1 and ram_wdata=wdata lane byte. On read, ram_we=0, and the byte returned for the previous cycle's lane is captured into rdata. After lane N-1, a write goes to DONE and a read goes to DRAIN.
  - DRAIN (read only, 1 cycle): capture the last lane byte; ram_we=0.
  - DONE (1 cycle): done=1 (fault=1 if aborted); next state IDLE.
- rdata is cleared at accept and holds its value after DONE until the next accept.
- Latency from accept edge to done-high cycle: write = N+2 cycles; read = N+3 cycles; N=0 or fault = 2 cycles.
- ram_we is never high outside RUN.
- Lane address arithmetic is taken as given; no wrap checking beyond the sentinel.
- A request presented while busy waits (req_ready=0); no queueing.
- Reset mid-operation abandons the transfer with no done pulse; bytes already written remain in the RAM.

Decomposition:
- Shared package holds:
  - control code constants (CTL_NONE=0, CTL_PUSH=1, CTL_POP=2, CTL_BYTE=3, CTL_HALF=4, CTL_WORD=5);
  - SENTINEL;
  - state encoding (IDLE, CHECK, RUN, DRAIN, DONE);
  - the lane-count function.
- One natural sub-module: lane_data_packer. It is combinational, handling wdata lane select and rdata byte insertion by lane index.

Test Plan:
- Word store: control=5, req_write=1, Address={10'd39,10'd40,10'd41,10'd42}, wdata=32'hAABBCCDD -> RAM[42]=DD, [41]=CC, [40]=BB, [39]=AA over 4 RUN cycles; done 6 cycles after accept; fault=0.
- Word load of the same location -> rdata=32'hAABBCCDD, done 7 cycles after accept, ram_we never high.
- Halfword load, Address lanes 0/1 = 20/19, RAM[20]=0x5A, [19]=0x3C -> rdata=32'h00003C5A.
- Pop of empty stack: control=2, Byte0=10'h3FF -> no RAM access, done=fault=1 two cycles after accept, rdata=0.
- Push at SP=36, wdata=32'h00000077, req_write=0 -> RAM[36]=0x77 (direction forced to write); req_ready stays low and a second req_valid is held off until after done.
- Reset asserted during the RUN cycle of lane 2 of a word store -> immediate IDLE, ram_we=0, no done pulse; RAM[42] and [41] written, [40] and [39] unchanged.
